// File: rtl/adder8_pkg.sv
// Shared constants and state encoding for the adder8 operand loader.
package adder8_pkg;

    // Default operand width in bits
    localparam int DW_DEFAULT = 8;

    // Loader FSM states; encoding 2'd3 is unused and recovers to WAIT_A
    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        HOLD   = 2'd2
    } ld_state_e;

endpackage

// File: rtl/strobe_edge_sync.sv
// Three-flop synchronizer for the asynchronous pad strobe plus rising-edge detect.
// The flops reset to 1 so a strobe held high through reset release is not
// mistaken for a fresh edge.
module strobe_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    output logic edge_pulse
);

    logic s1;
    logic s2;
    logic s3;

    // Shift the raw strobe through the synchronizer chain
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= strobe;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // One-cycle pulse when the synchronized strobe goes from low to high
    assign edge_pulse = s2 & ~s3;

endmodule

// File: rtl/adder8_operand_loader.sv
// Loads two operands and a carry-in from a shared pad bus on successive
// strobe edges and presents them to the adder with a valid/ready handshake.
// A strobe edge that arrives while a set is still pending is dropped and
// flagged on the sticky overrun output.
module adder8_operand_loader
    import adder8_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic [DW-1:0] data_in,
    input  logic          strobe,
    input  logic          cin_in,
    input  logic          clr_ovr,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    output logic          op_cin,
    output logic          op_valid,
    input  logic          op_ready,
    output logic          overrun,
    output logic [1:0]    state_dbg
);

    logic       edge_pulse;
    logic [1:0] state;

    strobe_edge_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .strobe     (strobe),
        .edge_pulse (edge_pulse)
    );

    // Loader FSM with operand capture, handshake and overrun tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= WAIT_A;
            op_a     <= '0;
            op_b     <= '0;
            op_cin   <= 1'b0;
            op_valid <= 1'b0;
            overrun  <= 1'b0;
        end else if (ena) begin
            // Clear first so a same-cycle overrun set below takes priority
            if (clr_ovr) begin
                overrun <= 1'b0;
            end
            case (state)
                WAIT_A: begin
                    if (edge_pulse) begin
                        op_a  <= data_in;
                        state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (edge_pulse) begin
                        op_b     <= data_in;
                        op_cin   <= cin_in;
                        op_valid <= 1'b1;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (op_valid && op_ready) begin
                        op_valid <= 1'b0;
                        if (edge_pulse) begin
                            // Handshake and new edge together: start the next set
                            op_a  <= data_in;
                            state <= WAIT_B;
                        end else begin
                            state <= WAIT_A;
                        end
                    end else if (edge_pulse) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    op_valid <= 1'b0;
                    state    <= WAIT_A;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_adder8_operand_loader.sv
// Scoreboard bench for adder8_operand_loader: expected operand sets are queued
// as stimulus is applied and compared when the DUT completes a handshake.
module tb_adder8_operand_loader;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          ena;
    logic [DW-1:0] data_in;
    logic          strobe;
    logic          cin_in;
    logic          clr_ovr;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          op_cin;
    logic          op_valid;
    logic          op_ready;
    logic          overrun;
    logic [1:0]    state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    int vld_cycles = 0;
    int vld_base;

    logic [2*DW:0] sb_q[$];
    logic [2*DW:0] sb_exp;

    adder8_operand_loader #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .data_in   (data_in),
        .strobe    (strobe),
        .cin_in    (cin_in),
        .clr_ovr   (clr_ovr),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_cin    (op_cin),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .overrun   (overrun),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [DW-1:0] d, input logic c);
        data_in = d;
        cin_in  = c;
        strobe  = 1'b1;
        repeat (3) tick();
        strobe  = 1'b0;
        repeat (3) tick();
    endtask

    // Handshake monitor: pop and compare one expected set per accepted transfer
    always @(negedge clk) begin
        if (!rst && op_valid) begin
            vld_cycles++;
        end
        if (!rst && ena && op_valid && op_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected", 32'd1, 32'd0);
            end else begin
                sb_exp = sb_q.pop_front();
                check_eq("sb_ops", {15'd0, op_a, op_b, op_cin}, {15'd0, sb_exp});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout reached without finishing");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ena = 1'b1; data_in = '0; strobe = 1'b0;
        cin_in = 1'b0; clr_ovr = 1'b0; op_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_eq("rst_op_a", 32'(op_a), 32'h0);
        check_eq("rst_op_b", 32'(op_b), 32'h0);
        check_eq("rst_flags", {28'd0, op_cin, op_valid, overrun, 1'b0}, 32'h0);
        check_eq("rst_state", 32'(state_dbg), 32'd0);

        // Basic load with immediate acceptance
        op_ready = 1'b1;
        sb_q.push_back({8'h3C, 8'hA5, 1'b1});
        pulse(8'h3C, 1'b0);
        check_eq("basic_state_b", 32'(state_dbg), 32'd1);
        check_eq("basic_op_a", 32'(op_a), 32'h3C);
        vld_base = vld_cycles;
        pulse(8'hA5, 1'b1);
        check_eq("basic_vld_cycles", 32'(vld_cycles - vld_base), 32'd1);
        check_eq("basic_state_end", 32'(state_dbg), 32'd0);
        check_eq("basic_op_b", 32'(op_b), 32'hA5);
        check_eq("basic_op_cin", 32'(op_cin), 32'd1);

        // Capture latency: strobe sampled at edge k, op_a updates at k+2
        data_in = 8'h11; cin_in = 1'b0; strobe = 1'b1;
        tick();
        check_eq("lat_k", 32'(op_a), 32'h3C);
        tick();
        check_eq("lat_k1", 32'(op_a), 32'h3C);
        tick();
        check_eq("lat_k2", 32'(op_a), 32'h11);
        strobe = 1'b0;
        repeat (3) tick();
        sb_q.push_back({8'h11, 8'h22, 1'b0});
        pulse(8'h22, 1'b0);

        // Backpressure and overrun
        op_ready = 1'b0;
        sb_q.push_back({8'h01, 8'h02, 1'b0});
        pulse(8'h01, 1'b0);
        pulse(8'h02, 1'b0);
        repeat (20) tick();
        check_eq("bp_valid_held", 32'(op_valid), 32'd1);
        check_eq("bp_state_hold", 32'(state_dbg), 32'd2);
        pulse(8'hFF, 1'b1);
        check_eq("bp_overrun", 32'(overrun), 32'd1);
        check_eq("bp_op_a", 32'(op_a), 32'h01);
        check_eq("bp_op_b", 32'(op_b), 32'h02);
        check_eq("bp_op_cin", 32'(op_cin), 32'd0);
        check_eq("bp_valid_after", 32'(op_valid), 32'd1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check_eq("bp_clr_ovr", 32'(overrun), 32'd0);
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        check_eq("bp_drain_state", 32'(state_dbg), 32'd0);
        check_eq("bp_drain_valid", 32'(op_valid), 32'd0);

        // Edge and ready in the same cycle while holding
        sb_q.push_back({8'h33, 8'h44, 1'b1});
        pulse(8'h33, 1'b0);
        pulse(8'h44, 1'b1);
        data_in = 8'h77; cin_in = 1'b0; strobe = 1'b1;
        tick();
        tick();
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        check_eq("sim_valid", 32'(op_valid), 32'd0);
        check_eq("sim_op_a", 32'(op_a), 32'h77);
        check_eq("sim_state", 32'(state_dbg), 32'd1);
        check_eq("sim_overrun", 32'(overrun), 32'd0);
        strobe = 1'b0;
        repeat (3) tick();
        sb_q.push_back({8'h77, 8'h88, 1'b0});
        op_ready = 1'b1;
        pulse(8'h88, 1'b0);
        op_ready = 1'b0;

        // Enable low discards the edge
        ena = 1'b0;
        pulse(8'h55, 1'b0);
        check_eq("ena_state", 32'(state_dbg), 32'd0);
        check_eq("ena_op_a", 32'(op_a), 32'h77);
        ena = 1'b1;
        pulse(8'h55, 1'b0);
        check_eq("ena_capture", 32'(op_a), 32'h55);
        check_eq("ena_state_b", 32'(state_dbg), 32'd1);

        // Reset in WAIT_B with strobe held high across release
        data_in = 8'h66; strobe = 1'b1; rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        check_eq("rst2_op_a", 32'(op_a), 32'h0);
        check_eq("rst2_op_b", 32'(op_b), 32'h0);
        check_eq("rst2_flags", {28'd0, op_cin, op_valid, overrun, 1'b0}, 32'h0);
        check_eq("rst2_state", 32'(state_dbg), 32'd0);
        strobe = 1'b0;
        repeat (3) tick();
        check_eq("rst2_no_edge", 32'(state_dbg), 32'd0);
        sb_q.push_back({8'h12, 8'h34, 1'b1});
        op_ready = 1'b1;
        pulse(8'h12, 1'b0);
        check_eq("rst2_one_edge_valid", 32'(op_valid), 32'd0);
        check_eq("rst2_one_edge_state", 32'(state_dbg), 32'd1);
        pulse(8'h34, 1'b1);
        op_ready = 1'b0;

        repeat (3) tick();
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adder8_operand_loader.md
ADDER8_OPERAND_LOADER -- requirements
Module: adder8_operand_loader

Interface
REQ-001 SHALL have parameter DW, default 8, operand width in bits.
REQ-002 SHALL have port clk  input  1  sole clock, all flops rising-edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port ena  input  1  design enable; low freezes FSM and capture registers.
REQ-005 SHALL have port data_in  input  DW  operand byte from pads, stable while strobe high.
REQ-006 SHALL have port strobe  input  1  asynchronous load strobe from pad; rising edge loads data_in.
REQ-007 SHALL have port cin_in  input  1  carry-in, captured together with operand B.
REQ-008 SHALL have port clr_ovr  input  1  synchronous clear of overrun flag.
REQ-009 SHALL have port op_a  output  DW  registered operand A to adder.
REQ-010 SHALL have port op_b  output  DW  registered operand B to adder.
REQ-011 SHALL have port op_cin  output  1  registered carry-in to adder.
REQ-012 SHALL have port op_valid  output  1  operand set valid.
REQ-013 SHALL have port op_ready  input  1  adder accepts operand set.
REQ-014 SHALL have port overrun  output  1  sticky: strobe edge lost while holding.
REQ-015 SHALL have port state_dbg  output  2  current FSM state encoding.

Function
REQ-016 SHALL pass strobe through a 3-flop chain s1,s2,s3; edge pulse = s2 AND NOT s3.
REQ-017 SHALL thus raise edge pulse in the cycle after the second clk edge that samples strobe high, and capture on the third.
REQ-018 SHALL implement FSM states WAIT_A=0, WAIT_B=1, HOLD=2; encoding 3 unused, recovers to WAIT_A next cycle.
REQ-019 WAIT_A: edge with ena -> op_a <= data_in, go WAIT_B.
REQ-020 WAIT_B: edge with ena -> op_b <= data_in, op_cin <= cin_in, op_valid <= 1, go HOLD.
REQ-021 HOLD: op_valid AND op_ready -> op_valid <= 0, go WAIT_A; op_a/op_b/op_cin keep values.
REQ-022 HOLD: op_a, op_b, op_cin SHALL not change while op_valid high without op_ready.
REQ-023 HOLD, edge without op_ready: overrun <= 1, data_in discarded, state unchanged.
REQ-024 HOLD, edge and op_ready same cycle: handshake completes, op_a <= data_in, go WAIT_B, overrun unchanged.
REQ-025 ena low: FSM, op_* and overrun hold; synchronizer keeps running; edge pulses discarded, not queued.
REQ-026 op_ready low-to-high while op_valid low SHALL have no effect.
REQ-027 clr_ovr high: overrun <= 0; if same cycle sets overrun (REQ-023), set wins.
REQ-028 Operands SHALL pass unmodified, no arithmetic; full DW bits captured, no truncation.

Reset
REQ-029 rst high at a clk edge: state WAIT_A, op_a=0, op_b=0, op_cin=0, op_valid=0, overrun=0, regardless of ena.
REQ-030 s1,s2,s3 SHALL reset to 1, so strobe held high through reset release produces no edge.
REQ-031 rst mid-operation (WAIT_B or HOLD) SHALL discard partial/pending operands; no op_valid until two new edges.

Structure
REQ-032 Package adder8_pkg SHALL hold DW default constant and the FSM state enum.
REQ-033 Synchronizer and edge detect SHALL be sub-module strobe_edge_sync (ports clk, rst, strobe, edge).
REQ-034 All outputs SHALL be driven directly from flops.

Verification
REQ-035 Basic: data_in=0x3C strobe pulse, data_in=0xA5 cin_in=1 pulse, op_ready=1 -> op_a=0x3C, op_b=0xA5, op_cin=1, op_valid one cycle, state back to 0.
REQ-036 Backpressure: load 0x01/0x02, op_ready=0 20 cycles, third strobe pulse data 0xFF -> op_valid stays 1, op_a/op_b unchanged, overrun=1; clr_ovr -> 0.
REQ-037 Simultaneous: in HOLD, edge pulse and op_ready same cycle with data_in=0x77 -> op_valid 0, op_a=0x77, state_dbg=1, overrun=0.
REQ-038 Enable: ena=0 during strobe pulse 0x55 -> no capture, state 0; ena=1, pulse again -> op_a=0x55.
REQ-039 Reset: rst in WAIT_B with strobe held high, release -> all outputs 0, state 0, no capture until strobe falls and rises.
REQ-040 Latency: strobe high sampled at edge k -> op_a updated at edge k+2, not k+1 or k+3.
